// File: rtl/comparador_serial_dl.sv
`default_nettype none
// comparador_serial_dl: LSB-first serial magnitude comparator, one bit pair per clock (M: A>B, N: A<B, Z: A>=B).
// Define COMPARADOR_TRAZA_EN to add the per-bit running-verdict trace outputs Mt/Nt.  Rev 1.0
module comparador_serial_dl #(
  parameter int K = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         M,
  output logic         N,
  output logic         Z
`ifdef COMPARADOR_TRAZA_EN
  ,
  output logic [K-1:0] Mt,
  output logic [K-1:0] Nt
`endif
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [K-1:0]  sa;
  logic [K-1:0]  sb;
  logic [CW-1:0] cnt;
  logic          m;
  logic          n;
  logic          step_m;
  logic          step_n;

  // A differing bit always overrides the verdict built from lower-order bits.
  always_comb begin
    step_m = m;
    step_n = n;
    if (sa[0] & ~sb[0]) begin
      step_m = 1'b1;
      step_n = 1'b0;
    end else if (~sa[0] & sb[0]) begin
      step_m = 1'b0;
      step_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      M     <= 1'b0;
      N     <= 1'b0;
      Z     <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      m     <= 1'b0;
      n     <= 1'b0;
`ifdef COMPARADOR_TRAZA_EN
      Mt    <= '0;
      Nt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            sa    <= A;
            sb    <= B;
            cnt   <= '0;
            m     <= 1'b0;
            n     <= 1'b0;
`ifdef COMPARADOR_TRAZA_EN
            Mt    <= '0;
            Nt    <= '0;
`endif
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          m   <= step_m;
          n   <= step_n;
          cnt <= cnt + 1'b1;
`ifdef COMPARADOR_TRAZA_EN
          Mt[cnt] <= step_m;
          Nt[cnt] <= step_n;
`endif
          if (cnt == LAST) begin
            // Result registers see the verdict including the MSB in the same edge.
            M     <= step_m;
            N     <= step_n;
            Z     <= ~step_n;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comparador_serial_dl.sv
`default_nettype none
// tb_comparador_serial_dl: directed stimulus with a cycle-level behavioural model and per-cycle output compare.
module tb_comparador_serial_dl;
  localparam int K = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [K-1:0] A = '0;
  logic [K-1:0] B = '0;
  logic busy, done, M, N, Z;
`ifdef COMPARADOR_TRAZA_EN
  logic [K-1:0] Mt, Nt;
`endif

  comparador_serial_dl #(.K(K)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .M(M), .N(N), .Z(Z)
`ifdef COMPARADOR_TRAZA_EN
    , .Mt(Mt), .Nt(Nt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a comparison occupies K busy clocks after acceptance, then reports plain integer ordering.
  logic e_busy = 0, e_done = 0, e_M = 0, e_N = 0, e_Z = 0;
  logic [K-1:0] pa = '0, pb = '0;
  int rem = 0, proc = 0;

  always @(posedge clk) begin
    if (reset) begin
      e_busy = 0; e_done = 0; e_M = 0; e_N = 0; e_Z = 0; rem = 0; proc = 0;
    end else begin
      e_done = 0;
      if (rem > 0) begin
        rem--;
        proc++;
        if (rem == 0) begin
          e_done = 1; e_busy = 0;
          e_M = (pa > pb); e_N = (pa < pb); e_Z = (pa >= pb);
        end
      end else if (start) begin
        pa = A; pb = B; rem = K; proc = 0; e_busy = 1;
      end
    end
  end

  // Trace bit i is the ordering of the low i+1 bits once bit i has been consumed.
  function automatic logic [K-1:0] trace(input bit greater);
    logic [K-1:0] r, mk;
    r = '0;
    for (int i = 0; i < K; i++) begin
      mk = {K{1'b1}} >> (K - 1 - i);
      if (i < proc) r[i] = greater ? ((pa & mk) > (pb & mk)) : ((pa & mk) < (pb & mk));
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("M", 32'(M), 32'(e_M));
      chk("N", 32'(N), 32'(e_N));
      chk("Z", 32'(Z), 32'(e_Z));
`ifdef COMPARADOR_TRAZA_EN
      chk("Mt", 32'(Mt), 32'(trace(1'b1)));
      chk("Nt", 32'(Nt), 32'(trace(1'b0)));
`endif
    end
  end

  task automatic wait_done(input int limit, output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) busy_n++;
    end while (!done && cyc < limit);
  endtask

  task automatic run_cmp(input logic [K-1:0] a, input logic [K-1:0] b,
                         input logic [2:0] mnz, input string nm);
    int cyc, bn;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    wait_done(20, cyc, bn);
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(cyc), 32'(K + 1));
    chk({nm, "_busy_cycles"}, 32'(bn), 32'(K));
    chk({nm, "_MNZ"}, 32'({M, N, Z}), 32'(mnz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bn, dn;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_state", 32'({busy, done, M, N, Z}), 32'd0);
    reset = 1'b0;

    run_cmp(5'b10110, 5'b01111, 3'b101, "c1_22_vs_15");
    run_cmp(5'd13, 5'd13, 3'b001, "c2_equal");
    run_cmp(5'b01110, 5'b10001, 3'b010, "c3_msb_wins");
    run_cmp(5'b00001, 5'b00000, 3'b101, "c4_lsb_only");
    run_cmp(5'd0, 5'd31, 3'b010, "zero_vs_max");
    run_cmp(5'd31, 5'd31, 3'b001, "max_eq");
    run_cmp(5'd16, 5'd15, 3'b101, "msb_vs_rest");

    // Start while busy is ignored; start during the done cycle chains without a gap.
    @(negedge clk);
    A = 5'd3; B = 5'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 5'd24; B = 5'd3; start = 1'b1;
    wait_done(20, cyc, bn);
    chk("c5_first_latency", 32'(cyc + 2), 32'(K + 1));
    chk("c5_first_MNZ", 32'({M, N, Z}), 32'b010);
    A = 5'd24; B = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("c5_no_gap_busy", 32'(busy), 32'd1);
    chk("c5_no_gap_done", 32'(done), 32'd0);
    wait_done(20, cyc, bn);
    chk("c5_second_latency", 32'(cyc + 1), 32'(K + 1));
    chk("c5_second_MNZ", 32'({M, N, Z}), 32'b101);

    // Reset during RUN aborts with no trailing done pulse.
    @(negedge clk);
    A = 5'd22; B = 5'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("c6_after_reset", 32'({busy, done, M, N, Z}), 32'd0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("c6_no_done", 32'(dn), 32'd0);

    run_cmp(5'd7, 5'd9, 3'b010, "post_reset");

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
